// File: rtl/fir_cfg_pkg.sv
`default_nettype none
// ============================================================================
// fir_cfg_pkg: shared defaults, loader state encoding and range helpers.
// Rev 1.0
// ============================================================================
package fir_cfg_pkg;

  localparam int DEF_MAX_TAPS = 32;
  localparam int DEF_COEF_W   = 25;
  localparam int DEF_ADDR_W   = 5;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOAD  = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } loader_state_t;

  function automatic logic len_in_range(input logic [31:0] len, input int unsigned lim);
    return (len != 32'd0) && (len <= lim);
  endfunction

  function automatic logic addr_in_range(input logic [31:0] addr, input int unsigned lim);
    return addr < lim;
  endfunction

endpackage
`default_nettype wire

// File: rtl/coef_buf_ram.sv
`default_nettype none
// ============================================================================
// coef_buf_ram: simple dual-port coefficient buffer, 1-cycle synchronous read.
// Rev 1.0
// ============================================================================
module coef_buf_ram #(
  parameter int DEPTH = 32,
  parameter int WIDTH = 25,
  parameter int AW    = 5
) (
  input  logic             clk,
  input  logic             we,
  input  logic [AW-1:0]    waddr,
  input  logic [WIDTH-1:0] wdata,
  input  logic             re,
  input  logic [AW-1:0]    raddr,
  output logic [WIDTH-1:0] rdata
);

  logic [WIDTH-1:0] mem [DEPTH];

  // Output register clears when not reading, so the chain sees zero between loads.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
    rdata <= re ? mem[raddr] : '0;
  end

endmodule
`default_nettype wire

// File: rtl/fir_coef_loader.sv
`default_nettype none
// ============================================================================
// fir_coef_loader: shifts the CPU-written coefficient buffer into the FIR chain.
// Rev 1.0
// ============================================================================
module fir_coef_loader
  import fir_cfg_pkg::*;
#(
  parameter int MAX_TAPS = DEF_MAX_TAPS,
  parameter int COEF_W   = DEF_COEF_W,
  parameter int ADDR_W   = DEF_ADDR_W
) (
  input  logic              cfg_clk,
  input  logic              reset,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [COEF_W-1:0] wr_data,
  input  logic              start,
  input  logic [31:0]       filter_len,
  output logic              busy,
  output logic              done,
  output logic              err_len,
  output logic              wr_dropped,
  output logic [15:0]       load_count,
  output logic [COEF_W-1:0] cfg_din,
  output logic              cfg_ce
);

  loader_state_t     state;
  loader_state_t     state_nxt;
  logic [ADDR_W-1:0] rd_idx;
  logic              idle_like;
  logic              len_ok;
  logic              accept;
  logic              buf_we;
  logic              rd_en;

  always_ff @(posedge cfg_clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    idle_like = (state == IDLE) || (state == DONE);
    len_ok    = len_in_range(filter_len, MAX_TAPS);
    accept    = start && idle_like && len_ok;
    buf_we    = wr_en && idle_like && addr_in_range(32'(wr_addr), MAX_TAPS);
    // Gated by reset so the chain stops shifting the cycle after reset.
    rd_en     = (state == LOAD) && !reset;
    case (state)
      IDLE:    if (accept) state_nxt = LOAD;
      LOAD:    if (rd_idx == '0) state_nxt = DRAIN;
      DRAIN:   state_nxt = DONE;
      DONE:    state_nxt = accept ? LOAD : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  assign busy = (state == LOAD) || (state == DRAIN);
  assign done = (state == DONE);

  always_ff @(posedge cfg_clk) begin
    if (reset) begin
      err_len    <= 1'b0;
      wr_dropped <= 1'b0;
      load_count <= '0;
      cfg_ce     <= 1'b0;
      rd_idx     <= '0;
    end else begin
      cfg_ce <= rd_en;
      if (start && idle_like) begin
        err_len <= !len_ok;
      end
      // Reads run from the deepest tap down so buf[0] is shifted in last.
      if (accept) begin
        wr_dropped <= 1'b0;
        rd_idx     <= filter_len[ADDR_W-1:0] - 1'b1;
      end else begin
        if (wr_en && busy) begin
          wr_dropped <= 1'b1;
        end
        if (state == LOAD) begin
          rd_idx <= rd_idx - 1'b1;
        end
      end
      if (state == DRAIN) begin
        load_count <= load_count + 1'b1;
      end
    end
  end

  coef_buf_ram #(
    .DEPTH (MAX_TAPS),
    .WIDTH (COEF_W),
    .AW    (ADDR_W)
  ) u_buf (
    .clk   (cfg_clk),
    .we    (buf_we),
    .waddr (wr_addr),
    .wdata (wr_data),
    .re    (rd_en),
    .raddr (rd_idx),
    .rdata (cfg_din)
  );

endmodule
`default_nettype wire
